// File: rtl/dc_cal_sequencer_if.sv
// rtl/dc_cal_sequencer_if.sv - mic DC-offset calibration sequencer signal bundle
interface dc_cal_sequencer_if;
  logic        mic_data_valid;
  logic        recal_req;
  logic        offset_produced;
  logic [15:0] offset_in;
  logic        offset_trigger;
  logic [15:0] offset_out;
  logic        offset_valid;
  logic        cal_busy;
  logic        cal_error;
  logic [3:0]  retry_count;
  logic [2:0]  state_out;

  modport slave (
    input  mic_data_valid, recal_req, offset_produced, offset_in,
    output offset_trigger, offset_out, offset_valid, cal_busy, cal_error,
           retry_count, state_out
  );

  modport master (
    output mic_data_valid, recal_req, offset_produced, offset_in,
    input  offset_trigger, offset_out, offset_valid, cal_busy, cal_error,
           retry_count, state_out
  );
endinterface

// File: rtl/dc_cal_sequencer.sv
// rtl/dc_cal_sequencer.sv - mic DC-offset calibration sequencer
module dc_cal_sequencer #(
  parameter int unsigned SETTLE_SAMPLES  = 4800,
  parameter int unsigned TIMEOUT_SAMPLES = 65535,
  parameter int unsigned OFFSET_LIMIT    = 8192,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter bit          AUTO_START      = 1'b1
) (
  input  logic              audio_clk,
  input  logic              rst_in,
  dc_cal_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_TRIGGER = 3'd2,
    S_WAIT    = 3'd3,
    S_CHECK   = 3'd4,
    S_RUN     = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  localparam logic [15:0] SETTLE_N  = 16'(SETTLE_SAMPLES);
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_SAMPLES);
  localparam logic [16:0] LIMIT_N   = 17'(OFFSET_LIMIT);
  localparam logic [3:0]  RETRY_N   = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic        auto_q;
  logic [15:0] settle_q, settle_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] cand_q, cand_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] offset_q, offset_d;
  logic        valid_q, valid_d;
  logic        trig_q, busy_q, err_q;
  logic        fail_attempt;
  logic [16:0] cand_ext, cand_abs;

  // Magnitude in 17 bits so that -32768 maps to +32768 and is rejected
  assign cand_ext = {cand_q[15], cand_q};
  assign cand_abs = cand_q[15] ? (17'd0 - cand_ext) : cand_ext;

  // Next-state, counter and result logic
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    tmo_d        = tmo_q;
    cand_d       = cand_q;
    retry_d      = retry_q;
    offset_d     = offset_q;
    valid_d      = valid_q;
    fail_attempt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (auto_q || bus.recal_req) begin
          state_d  = S_SETTLE;
          retry_d  = 4'd0;
          settle_d = 16'd0;
        end
      end
      S_SETTLE: begin
        if (bus.mic_data_valid) begin
          if (settle_q + 16'd1 >= SETTLE_N) begin
            state_d  = S_TRIGGER;
            settle_d = 16'd0;
          end else begin
            settle_d = settle_q + 16'd1;
          end
        end
      end
      S_TRIGGER: begin
        tmo_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.offset_produced) begin
          cand_d  = bus.offset_in;
          state_d = S_CHECK;
        end else if (bus.mic_data_valid) begin
          if (tmo_q + 16'd1 >= TIMEOUT_N) begin
            tmo_d        = TIMEOUT_N;
            fail_attempt = 1'b1;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end
      S_CHECK: begin
        if (cand_abs <= LIMIT_N) begin
          offset_d = cand_q;
          valid_d  = 1'b1;
          state_d  = S_RUN;
        end else begin
          fail_attempt = 1'b1;
        end
      end
      S_RUN, S_FAIL: begin
        if (bus.recal_req) begin
          state_d  = S_SETTLE;
          retry_d  = 4'd0;
          settle_d = 16'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_attempt) begin
      retry_d  = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
      settle_d = 16'd0;
      state_d  = (retry_d == RETRY_N) ? S_FAIL : S_SETTLE;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      auto_q   <= AUTO_START;
      settle_q <= 16'd0;
      tmo_q    <= 16'd0;
      cand_q   <= 16'd0;
      retry_q  <= 4'd0;
      offset_q <= 16'd0;
      valid_q  <= 1'b0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      auto_q   <= 1'b0;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      cand_q   <= cand_d;
      retry_q  <= retry_d;
      offset_q <= offset_d;
      valid_q  <= valid_d;
      trig_q   <= (state_d == S_TRIGGER);
      busy_q   <= (state_d == S_SETTLE) || (state_d == S_TRIGGER) ||
                  (state_d == S_WAIT)   || (state_d == S_CHECK);
      err_q    <= (state_d == S_FAIL);
    end
  end

  assign bus.offset_trigger = trig_q;
  assign bus.offset_out     = offset_q;
  assign bus.offset_valid   = valid_q;
  assign bus.cal_busy       = busy_q;
  assign bus.cal_error      = err_q;
  assign bus.retry_count    = retry_q;
  assign bus.state_out      = state_q;

endmodule

// File: tb/tb_dc_cal_sequencer.sv
// tb/tb_dc_cal_sequencer.sv - scoreboard bench for dc_cal_sequencer
module tb_dc_cal_sequencer;

  localparam int ST_IDLE = 0, ST_SETTLE = 1, ST_TRIG = 2, ST_WAIT = 3;
  localparam int ST_CHECK = 4, ST_RUN = 5, ST_FAIL = 6;

  typedef struct {
    int st;
    int val;
    int vld;
    int rty;
  } exp_t;

  logic audio_clk = 1'b0;
  logic rst_in    = 1'b1;
  dc_cal_sequencer_if sb ();

  dc_cal_sequencer #(
    .SETTLE_SAMPLES (4),
    .TIMEOUT_SAMPLES(8),
    .OFFSET_LIMIT   (1000),
    .MAX_RETRIES    (3),
    .AUTO_START     (1'b1)
  ) dut (
    .audio_clk(audio_clk),
    .rst_in   (rst_in),
    .bus      (sb)
  );

  always #5 audio_clk = ~audio_clk;

  exp_t exp_q[$];
  int   tests     = 0;
  int   fails     = 0;
  int   cyc       = 0;
  int   trig_cnt  = 0;
  int   wait_strb = 0;
  int   prev_st   = 0;
  bit   watch     = 1'b0;
  bit   hold_ok   = 1'b1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int out_val();
    return int'($signed(sb.offset_out));
  endfunction

  task automatic expect_evt(input int st, input int val, input int vld, input int rty);
    exp_t e;
    e.st = st; e.val = val; e.vld = vld; e.rty = rty;
    exp_q.push_back(e);
  endtask

  // One clock: sample after the edge, run the monitor, drive the next strobe
  task automatic step();
    if (int'(sb.state_out) == ST_WAIT && sb.mic_data_valid && !sb.offset_produced)
      wait_strb++;
    @(posedge audio_clk);
    #1;
    cyc++;
    if (sb.offset_trigger) begin
      trig_cnt++;
      wait_strb = 0;
    end
    if (watch && int'(sb.state_out) != ST_RUN &&
        (out_val() != 100 || sb.offset_valid !== 1'b1))
      hold_ok = 1'b0;
    if (int'(sb.state_out) != prev_st &&
        (int'(sb.state_out) == ST_RUN || int'(sb.state_out) == ST_FAIL)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_evt", int'(sb.state_out), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_state", int'(sb.state_out), e.st);
        check_eq("sb_offset_out", out_val(), e.val);
        check_eq("sb_offset_valid", int'(sb.offset_valid), e.vld);
        check_eq("sb_retry_count", int'(sb.retry_count), e.rty);
      end
    end
    prev_st = int'(sb.state_out);
    sb.mic_data_valid = (cyc % 4 == 0);
  endtask

  task automatic wait_trigger(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (sb.offset_trigger) seen = 1'b1;
    end
    check_eq(tag, int'(seen), 1);
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (int'(sb.state_out) == st) seen = 1'b1;
    end
    check_eq(tag, int'(seen), 1);
  endtask

  // From the TRIGGER cycle: enter WAIT, return one result, land in CHECK
  task automatic respond(input int val);
    step();
    sb.offset_in       = 16'(val);
    sb.offset_produced = 1'b1;
    step();
    sb.offset_produced = 1'b0;
  endtask

  task automatic recal();
    sb.recal_req = 1'b1;
    step();
    sb.recal_req = 1'b0;
  endtask

  initial begin
    sb.mic_data_valid  = 1'b0;
    sb.recal_req       = 1'b0;
    sb.offset_produced = 1'b0;
    sb.offset_in       = 16'd0;

    // Reset state
    step();
    step();
    check_eq("rst_state", int'(sb.state_out), ST_IDLE);
    check_eq("rst_valid", int'(sb.offset_valid), 0);
    check_eq("rst_busy", int'(sb.cal_busy), 0);
    check_eq("rst_trigger", int'(sb.offset_trigger), 0);
    rst_in = 1'b0;
    step();
    check_eq("auto_start_settle", int'(sb.state_out), ST_SETTLE);
    check_eq("auto_start_busy", int'(sb.cal_busy), 1);

    // T1 nominal
    trig_cnt = 0;
    expect_evt(ST_RUN, -910, 1, 0);
    wait_trigger(40, "t1_trigger_seen");
    check_eq("t1_one_trigger", trig_cnt, 1);
    respond(-910);
    check_eq("t1_check_state", int'(sb.state_out), ST_CHECK);
    check_eq("t1_valid_not_yet", int'(sb.offset_valid), 0);
    step();
    check_eq("t1_valid_latency", int'(sb.offset_valid), 1);
    check_eq("t1_trigger_count", trig_cnt, 1);

    // T2 range reject then accept
    recal();
    check_eq("t2_retry_cleared", int'(sb.retry_count), 0);
    wait_trigger(40, "t2_trigger1");
    respond(1500);
    step();
    check_eq("t2_reject_settle", int'(sb.state_out), ST_SETTLE);
    check_eq("t2_retry_one", int'(sb.retry_count), 1);
    check_eq("t2_hold_old", out_val(), -910);
    expect_evt(ST_RUN, 999, 1, 1);
    wait_trigger(40, "t2_trigger2");
    respond(999);
    step();

    // T3 timeouts to FAIL from a fresh reset
    rst_in = 1'b1;
    step();
    rst_in   = 1'b0;
    prev_st  = 0;
    trig_cnt = 0;
    expect_evt(ST_FAIL, 0, 0, 3);
    wait_state(ST_FAIL, 400, "t3_reach_fail");
    check_eq("t3_triggers", trig_cnt, 3);
    check_eq("t3_cal_error", int'(sb.cal_error), 1);
    recal();
    check_eq("t3_recal_retry", int'(sb.retry_count), 0);
    check_eq("t3_recal_error_clr", int'(sb.cal_error), 0);
    wait_trigger(40, "t3_new_trigger");
    expect_evt(ST_RUN, 100, 1, 0);
    respond(100);
    step();

    // T4 recal from RUN keeps the old result until a new one is accepted
    watch   = 1'b1;
    hold_ok = 1'b1;
    sb.recal_req = 1'b1;
    step();
    check_eq("t4_restart", int'(sb.state_out), ST_SETTLE);
    wait_trigger(40, "t4_trigger");
    step();
    step();
    step();
    check_eq("t4_recal_ignored_wait", int'(sb.state_out), ST_WAIT);
    sb.recal_req = 1'b0;
    expect_evt(ST_RUN, 200, 1, 0);
    sb.offset_in       = 16'd200;
    sb.offset_produced = 1'b1;
    step();
    sb.offset_produced = 1'b0;
    step();
    watch = 1'b0;
    check_eq("t4_hold_throughout", int'(hold_ok), 1);

    // T5 edges: TRIGGER-cycle result ignored, -32768 rejected
    recal();
    wait_trigger(40, "t5_trigger1");
    sb.offset_in       = 16'h8000;
    sb.offset_produced = 1'b1;
    step();
    sb.offset_produced = 1'b0;
    check_eq("t5_trig_result_ignored", int'(sb.state_out), ST_WAIT);
    sb.offset_produced = 1'b1;
    step();
    sb.offset_produced = 1'b0;
    step();
    check_eq("t5_min_rejected", int'(sb.state_out), ST_SETTLE);
    check_eq("t5_min_retry", int'(sb.retry_count), 1);

    // T5 result and final timeout strobe in the same cycle
    wait_trigger(40, "t5_trigger2");
    begin
      bit armed;
      armed = 1'b0;
      for (int i = 0; i < 100 && !armed; i++) begin
        step();
        if (wait_strb == 7 && sb.mic_data_valid) armed = 1'b1;
      end
      check_eq("t5_tie_armed", int'(armed), 1);
    end
    expect_evt(ST_RUN, 500, 1, 1);
    sb.offset_in       = 16'd500;
    sb.offset_produced = 1'b1;
    step();
    sb.offset_produced = 1'b0;
    check_eq("t5_tie_to_check", int'(sb.state_out), ST_CHECK);
    step();

    // T5 asynchronous reset in WAIT
    recal();
    wait_trigger(40, "t5_trigger3");
    step();
    #2;
    rst_in = 1'b1;
    #1;
    check_eq("t5_arst_state", int'(sb.state_out), ST_IDLE);
    check_eq("t5_arst_valid", int'(sb.offset_valid), 0);
    check_eq("t5_arst_offset", out_val(), 0);
    check_eq("t5_arst_busy", int'(sb.cal_busy), 0);
    step();
    rst_in  = 1'b0;
    prev_st = 0;

    // Reset during the trigger pulse
    wait_trigger(40, "t5_trigger4");
    rst_in = 1'b1;
    #1;
    check_eq("t5_arst_trigger", int'(sb.offset_trigger), 0);
    step();
    rst_in = 1'b0;

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
